// File: rtl/palette_fetch_seq_pkg.sv
// Shared video definitions: fetch state encoding, transparent code and palette address layout.
package palette_fetch_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_OBJ0 = 3'd1,
    ST_OBJ1 = 3'd2,
    ST_TM0  = 3'd3,
    ST_TM1  = 3'd4,
    ST_CAP  = 3'd5
  } fetch_state_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic [3:0] i;
  } colour_t;

  localparam logic [3:0]  TRANSPARENT_CODE = 4'hF;
  localparam int unsigned FETCH_CLKS       = 5;

  localparam int unsigned ADDR_SEL_BIT  = 10;
  localparam int unsigned ADDR_BYTE_BIT = 0;
  localparam logic        SEL_OBJ       = 1'b0;
  localparam logic        SEL_TM        = 1'b1;
  localparam logic        BYTE_RG       = 1'b0;
  localparam logic        BYTE_BI       = 1'b1;

  function automatic logic is_transparent(input logic [3:0] code_lsb);
    return code_lsb == TRANSPARENT_CODE;
  endfunction

  function automatic logic [10:0] pal_addr(input logic sel, input logic [8:0] idx,
                                           input logic byte_sel);
    logic [10:0] a;
    a = '0;
    a[ADDR_SEL_BIT] = sel;
    a[ADDR_SEL_BIT-1:ADDR_BYTE_BIT+1] = idx;
    a[ADDR_BYTE_BIT] = byte_sel;
    return a;
  endfunction

endpackage

// File: rtl/palette_fetch_seq.sv
// Fetches obj and tilemap colour words from palette RAM during one pixel slot;
// results appear on the outputs at the following i_PCEN (one slot of latency).
module palette_fetch_seq
  import palette_fetch_seq_pkg::*;
#(
  parameter int PIXPERIOD_MIN = 5
) (
  input  logic        i_EMU_MCLK,
  input  logic        i_EMU_MRST_n,
  input  logic        i_PCEN,
  input  logic        i_BLANK,
  input  logic [9:0]  i_OBJCODE,
  input  logic [9:0]  i_TMCODE,
  output logic [10:0] o_PALADDR,
  input  logic [7:0]  i_PALDATA,
  output logic [3:0]  o_OBJ_R,
  output logic [3:0]  o_OBJ_G,
  output logic [3:0]  o_OBJ_B,
  output logic [3:0]  o_OBJ_I,
  output logic [3:0]  o_TM_R,
  output logic [3:0]  o_TM_G,
  output logic [3:0]  o_TM_B,
  output logic [3:0]  o_TM_I,
  output logic        o_TMEN,
  output logic        o_OUTEN,
  output logic        o_OVERRUN
);

  if (PIXPERIOD_MIN < FETCH_CLKS) begin : g_period_chk
    $error("PIXPERIOD_MIN is shorter than the palette fetch sequence");
  end

  fetch_state_t state_q, state_d;
  logic [8:0]   obj_code_q, obj_code_d, tm_code_q, tm_code_d;
  logic         obj_transp_q, obj_transp_d, tm_transp_q, tm_transp_d;
  logic         blank_q, blank_d;
  logic         complete_q, complete_d;
  logic [10:0]  paladdr_q, paladdr_d;
  logic [7:0]   obj_rg_q, obj_rg_d, obj_bi_q, obj_bi_d;
  logic [7:0]   tm_rg_q, tm_rg_d, tm_bi_q, tm_bi_d;
  colour_t      obj_col_q, obj_col_d, tm_col_q, tm_col_d;
  logic         tmen_q, tmen_d, outen_q, outen_d, overrun_q, overrun_d;

  // The palette only holds 512 entries per layer, so code bit 9 is not addressed.
  logic unused_code_msb;
  assign unused_code_msb = i_OBJCODE[9] ^ i_TMCODE[9];

  always_comb begin
    state_d      = state_q;
    obj_code_d   = obj_code_q;
    tm_code_d    = tm_code_q;
    obj_transp_d = obj_transp_q;
    tm_transp_d  = tm_transp_q;
    blank_d      = blank_q;
    complete_d   = complete_q;
    paladdr_d    = paladdr_q;
    obj_rg_d     = obj_rg_q;
    obj_bi_d     = obj_bi_q;
    tm_rg_d      = tm_rg_q;
    tm_bi_d      = tm_bi_q;
    obj_col_d    = obj_col_q;
    tm_col_d     = tm_col_q;
    tmen_d       = tmen_q;
    outen_d      = outen_q;
    overrun_d    = overrun_q;

    // Each state captures the data returned for the previous state's address.
    unique case (state_q)
      ST_OBJ0: state_d = ST_OBJ1;
      ST_OBJ1: begin state_d = ST_TM0;  obj_rg_d = i_PALDATA; end
      ST_TM0:  begin state_d = ST_TM1;  obj_bi_d = i_PALDATA; end
      ST_TM1:  begin state_d = ST_CAP;  tm_rg_d  = i_PALDATA; end
      ST_CAP:  begin state_d = ST_IDLE; tm_bi_d  = i_PALDATA; complete_d = 1'b1; end
      default: state_d = ST_IDLE;
    endcase

    // Transfer uses the _d staging values so a pulse landing in CAP sees the last byte.
    if (i_PCEN) begin
      if (obj_transp_q) obj_col_d = '0;
      else              obj_col_d = colour_t'({obj_rg_d, obj_bi_d});
      tm_col_d = colour_t'({tm_rg_d, tm_bi_d});
      tmen_d   = !tm_transp_q;
      outen_d  = !blank_q;
      if (!complete_d) overrun_d = 1'b1;

      obj_code_d   = i_OBJCODE[8:0];
      tm_code_d    = i_TMCODE[8:0];
      obj_transp_d = is_transparent(i_OBJCODE[3:0]);
      tm_transp_d  = is_transparent(i_TMCODE[3:0]);
      blank_d      = i_BLANK;
      complete_d   = 1'b0;
      state_d      = ST_OBJ0;
    end

    unique case (state_d)
      ST_OBJ0: paladdr_d = pal_addr(SEL_OBJ, obj_code_d, BYTE_RG);
      ST_OBJ1: paladdr_d = pal_addr(SEL_OBJ, obj_code_d, BYTE_BI);
      ST_TM0:  paladdr_d = pal_addr(SEL_TM,  tm_code_d,  BYTE_RG);
      ST_TM1:  paladdr_d = pal_addr(SEL_TM,  tm_code_d,  BYTE_BI);
      default: paladdr_d = paladdr_q;
    endcase
  end

  always_ff @(posedge i_EMU_MCLK) begin
    if (!i_EMU_MRST_n) begin
      state_q      <= ST_IDLE;
      obj_code_q   <= '0;
      tm_code_q    <= '0;
      obj_transp_q <= 1'b0;
      tm_transp_q  <= 1'b0;
      blank_q      <= 1'b0;
      complete_q   <= 1'b1;
      paladdr_q    <= '0;
      obj_rg_q     <= '0;
      obj_bi_q     <= '0;
      tm_rg_q      <= '0;
      tm_bi_q      <= '0;
      obj_col_q    <= '0;
      tm_col_q     <= '0;
      tmen_q       <= 1'b0;
      outen_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      obj_code_q   <= obj_code_d;
      tm_code_q    <= tm_code_d;
      obj_transp_q <= obj_transp_d;
      tm_transp_q  <= tm_transp_d;
      blank_q      <= blank_d;
      complete_q   <= complete_d;
      paladdr_q    <= paladdr_d;
      obj_rg_q     <= obj_rg_d;
      obj_bi_q     <= obj_bi_d;
      tm_rg_q      <= tm_rg_d;
      tm_bi_q      <= tm_bi_d;
      obj_col_q    <= obj_col_d;
      tm_col_q     <= tm_col_d;
      tmen_q       <= tmen_d;
      outen_q      <= outen_d;
      overrun_q    <= overrun_d;
    end
  end

  assign o_PALADDR = paladdr_q;
  assign o_OBJ_R   = obj_col_q.r;
  assign o_OBJ_G   = obj_col_q.g;
  assign o_OBJ_B   = obj_col_q.b;
  assign o_OBJ_I   = obj_col_q.i;
  assign o_TM_R    = tm_col_q.r;
  assign o_TM_G    = tm_col_q.g;
  assign o_TM_B    = tm_col_q.b;
  assign o_TM_I    = tm_col_q.i;
  assign o_TMEN    = tmen_q;
  assign o_OUTEN   = outen_q;
  assign o_OVERRUN = overrun_q;

endmodule

// File: tb/tb_palette_fetch_seq.sv
// Bench for palette_fetch_seq: palette RAM model plus a scoreboard of expected pixels.
module tb_palette_fetch_seq;

  localparam int PIX_MIN = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pcen;
  logic        blank_in;
  logic [9:0]  objcode, tmcode;
  logic [10:0] paladdr;
  logic [7:0]  paldata;
  logic [3:0]  obj_r, obj_g, obj_b, obj_i, tm_r, tm_g, tm_b, tm_i;
  logic        tmen, outen, overrun;

  palette_fetch_seq #(.PIXPERIOD_MIN(PIX_MIN)) dut (
    .i_EMU_MCLK(clk), .i_EMU_MRST_n(rst_n), .i_PCEN(pcen), .i_BLANK(blank_in),
    .i_OBJCODE(objcode), .i_TMCODE(tmcode), .o_PALADDR(paladdr), .i_PALDATA(paldata),
    .o_OBJ_R(obj_r), .o_OBJ_G(obj_g), .o_OBJ_B(obj_b), .o_OBJ_I(obj_i),
    .o_TM_R(tm_r), .o_TM_G(tm_g), .o_TM_B(tm_b), .o_TM_I(tm_i),
    .o_TMEN(tmen), .o_OUTEN(outen), .o_OVERRUN(overrun)
  );

  always #5 clk = ~clk;

  // Synchronous palette RAM: data valid one clock after the address.
  logic [7:0] mem [0:2047];
  always @(posedge clk) paldata <= mem[paladdr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] obj;
    logic [15:0] tm;
    logic        tmen;
    logic        outen;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  bit   last_valid;
  bit   overrun_exp;
  int   last_cyc;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [10:0] addr_of(input logic sel, input logic [9:0] code, input logic b);
    return {sel, code[8:0], b};
  endfunction

  function automatic exp_t model(input logic [9:0] obj, input logic [9:0] tm, input logic blank);
    exp_t e;
    e.obj   = (obj[3:0] == 4'hF) ? 16'h0000
            : {mem[addr_of(1'b0, obj, 1'b0)], mem[addr_of(1'b0, obj, 1'b1)]};
    e.tm    = {mem[addr_of(1'b1, tm, 1'b0)], mem[addr_of(1'b1, tm, 1'b1)]};
    e.tmen  = (tm[3:0] != 4'hF);
    e.outen = !blank;
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    pcen  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    last_valid  = 1'b0;
    overrun_exp = 1'b0;
    last_cyc    = cyc;
  endtask

  // Drives one pixel `gap` clocks after the previous one and scores the transfer it causes.
  task automatic pixel(input logic [9:0] obj, input logic [9:0] tm, input logic blank,
                       input int gap);
    exp_t e;
    logic [15:0] act_obj, act_tm;
    while (cyc < last_cyc + gap - 1) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    if (last_valid) begin
      checks++;
      act_obj = {obj_r, obj_g, obj_b, obj_i};
      act_tm  = {tm_r, tm_g, tm_b, tm_i};
      if ({act_obj, act_tm, tmen, outen} !== {last_exp.obj, last_exp.tm, last_exp.tmen, last_exp.outen}) begin
        errors++;
        $display("FAIL hold: got obj=%h tm=%h tmen=%b outen=%b want obj=%h tm=%h tmen=%b outen=%b",
                 act_obj, act_tm, tmen, outen, last_exp.obj, last_exp.tm, last_exp.tmen, last_exp.outen);
      end
    end
    pcen     = 1'b1;
    objcode  = obj;
    tmcode   = tm;
    blank_in = blank;
    @(posedge clk);
    #1;
    pcen     = 1'b0;
    last_cyc = cyc;
    last_valid = 1'b0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (gap < PIX_MIN) begin
        overrun_exp = 1'b1;
      end else begin
        checks++;
        act_obj = {obj_r, obj_g, obj_b, obj_i};
        act_tm  = {tm_r, tm_g, tm_b, tm_i};
        if ({act_obj, act_tm, tmen, outen} !== {e.obj, e.tm, e.tmen, e.outen}) begin
          errors++;
          $display("FAIL pixel: got obj=%h tm=%h tmen=%b outen=%b want obj=%h tm=%h tmen=%b outen=%b",
                   act_obj, act_tm, tmen, outen, e.obj, e.tm, e.tmen, e.outen);
        end
        last_exp   = e;
        last_valid = 1'b1;
      end
    end
    checks++;
    if (overrun !== overrun_exp) begin
      errors++;
      $display("FAIL overrun_flag: got %b want %b", overrun, overrun_exp);
    end
    sb.push_back(model(obj, tm, blank));
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (paladdr !== 11'h000) begin errors++; $display("FAIL reset_addr: got %h want 000", paladdr); end
    checks++;
    if ({obj_r, obj_g, obj_b, obj_i, tm_r, tm_g, tm_b, tm_i} !== 32'h0) begin
      errors++;
      $display("FAIL reset_colour: got %h%h%h%h %h%h%h%h want 0", obj_r, obj_g, obj_b, obj_i, tm_r, tm_g, tm_b, tm_i);
    end
    checks++;
    if ({tmen, outen, overrun} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b%b%b want 000", tmen, outen, overrun);
    end
    release_reset();
  endtask

  task automatic test_basic();
    pixel(10'h012, 10'h034, 1'b0, 8);
    pixel(10'h0A5, 10'h1C7, 1'b0, 8);
    checks++;
    if ({obj_r, obj_g, obj_b, obj_i} !== 16'hABCD) begin
      errors++;
      $display("FAIL basic_obj: got %h%h%h%h want ABCD", obj_r, obj_g, obj_b, obj_i);
    end
    checks++;
    if ({tm_r, tm_g, tm_b, tm_i, tmen, outen} !== {16'h1234, 2'b11}) begin
      errors++;
      $display("FAIL basic_tm: got %h%h%h%h en=%b%b want 1234 en=11", tm_r, tm_g, tm_b, tm_i, tmen, outen);
    end
    pixel(10'h2E3, 10'h111, 1'b0, 8);
  endtask

  task automatic test_transparent();
    pixel(10'h01F, 10'h03F, 1'b0, 8);
    pixel(10'h055, 10'h066, 1'b0, 8);
    checks++;
    if ({obj_r, obj_g, obj_b, obj_i, tmen} !== 17'h0) begin
      errors++;
      $display("FAIL transparent: got obj=%h%h%h%h tmen=%b want 0 0", obj_r, obj_g, obj_b, obj_i, tmen);
    end
    pixel(10'h077, 10'h088, 1'b0, 8);
    checks++;
    if (tmen !== 1'b1) begin errors++; $display("FAIL opaque_tmen: got %b want 1", tmen); end
  endtask

  task automatic test_blank();
    pixel(10'h012, 10'h034, 1'b1, 8);
    pixel(10'h013, 10'h035, 1'b0, 8);
    checks++;
    if (outen !== 1'b0) begin errors++; $display("FAIL blank_outen: got %b want 0", outen); end
    pixel(10'h014, 10'h036, 1'b0, 8);
    checks++;
    if (outen !== 1'b1) begin errors++; $display("FAIL unblank_outen: got %b want 1", outen); end
  endtask

  task automatic test_min_period();
    do_reset();
    release_reset();
    pixel(10'h012, 10'h034, 1'b0, 8);
    for (int k = 0; k < 5; k++) pixel(10'(10'h100 + k * 37), 10'(10'h050 + k * 91), 1'b0, PIX_MIN);
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL min_period_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 12; k++)
      pixel(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
            1'($urandom_range(0, 1)), $urandom_range(PIX_MIN, 9));
  endtask

  task automatic test_overrun();
    pixel(10'h021, 10'h043, 1'b0, 8);
    pixel(10'h022, 10'h044, 1'b0, 3);
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b want 1", overrun); end
    pixel(10'h023, 10'h045, 1'b0, 8);
    pixel(10'h024, 10'h046, 1'b0, 8);
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
  endtask

  task automatic test_reset_mid_fetch();
    logic [10:0] seq [0:4];
    pixel(10'h031, 10'h052, 1'b0, 8);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (paladdr !== addr_of(1'b1, 10'h052, 1'b0)) begin
      errors++;
      $display("FAIL tm0_addr: got %h want %h", paladdr, addr_of(1'b1, 10'h052, 1'b0));
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({paladdr, obj_r, obj_g, obj_b, obj_i, tm_r, tm_g, tm_b, tm_i, tmen, outen, overrun} !== 46'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got addr=%h obj=%h%h%h%h tm=%h%h%h%h flags=%b%b%b want 0",
               paladdr, obj_r, obj_g, obj_b, obj_i, tm_r, tm_g, tm_b, tm_i, tmen, outen, overrun);
    end
    release_reset();
    seq[0] = addr_of(1'b0, 10'h033, 1'b0);
    seq[1] = addr_of(1'b0, 10'h033, 1'b1);
    seq[2] = addr_of(1'b1, 10'h054, 1'b0);
    seq[3] = addr_of(1'b1, 10'h054, 1'b1);
    seq[4] = seq[3];
    pixel(10'h033, 10'h054, 1'b0, 8);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      checks++;
      if (paladdr !== seq[k]) begin
        errors++;
        $display("FAIL addr_seq[%0d]: got %h want %h", k, paladdr, seq[k]);
      end
    end
    pixel(10'h034, 10'h055, 1'b0, 8);
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL post_reset_overrun: got %b want 0", overrun); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    pcen     = 1'b0;
    blank_in = 1'b0;
    objcode  = '0;
    tmcode   = '0;
    last_cyc = 0;
    last_valid  = 1'b0;
    overrun_exp = 1'b0;
    for (int a = 0; a < 2048; a++) mem[a] = 8'($urandom_range(0, 255));
    mem[11'h024] = 8'hAB;
    mem[11'h025] = 8'hCD;
    mem[11'h468] = 8'h12;
    mem[11'h469] = 8'h34;

    test_reset();
    test_basic();
    test_transparent();
    test_blank();
    test_min_period();
    test_back_to_back();
    test_overrun();
    test_reset_mid_fetch();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/palette_fetch_seq.md
PALETTE_FETCH_SEQ -- requirements
Module: palette_fetch_seq

Interface
REQ-001 SHALL have parameter PIXPERIOD_MIN, default 5: the minimum number of master clocks between i_PCEN pulses for a complete fetch.
REQ-002 SHALL have port i_EMU_MCLK, input, 1 bit: the single master clock; all logic is on the rising edge.
REQ-003 SHALL have port i_EMU_MRST_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port i_PCEN, input, 1 bit: pixel-slot strobe, one master clock wide.
REQ-005 SHALL have port i_BLANK, input, 1 bit: blanking for the pixel latched at the same i_PCEN.
REQ-006 SHALL have port i_OBJCODE, input, 10 bits: object palette index; bits [3:0]==4'hF means transparent.
REQ-007 SHALL have port i_TMCODE, input, 10 bits: tilemap palette index; bits [3:0]==4'hF means transparent.
REQ-008 SHALL have port o_PALADDR, output, 11 bits: palette RAM byte address {obj/tm select, code[9:0]} is wrong width; the address SHALL be {sel, code[8:0], byte}, where sel=0 for obj, sel=1 for tm, and byte=0 for {R,G}, byte=1 for {B,I}.
REQ-009 SHALL have port i_PALDATA, input, 8 bits: palette RAM read data, valid one clock after o_PALADDR.
REQ-010 SHALL have ports o_OBJ_R, o_OBJ_G, o_OBJ_B, o_OBJ_I, output, 4 bits each: object colour nibbles.
REQ-011 SHALL have ports o_TM_R, o_TM_G, o_TM_B, o_TM_I, output, 4 bits each: tilemap colour nibbles.
REQ-012 SHALL have port o_TMEN, output, 1 bit: the tilemap pixel is opaque.
REQ-013 SHALL have port o_OUTEN, output, 1 bit: the pixel is visible (not blanked).
REQ-014 SHALL have port o_OVERRUN, output, 1 bit: sticky flag, set when an i_PCEN arrives before the fetch has completed.

Function
REQ-015 SHALL use states IDLE, OBJ0, OBJ1, TM0, TM1, CAP, advancing one state per clock: OBJ0 -> OBJ1 -> TM0 -> TM1 -> CAP -> IDLE.
REQ-016 SHALL, on i_PCEN in any state, latch i_OBJCODE, i_TMCODE and i_BLANK into the fetch registers and enter OBJ0 on the next clock.
REQ-017 SHALL drive o_PALADDR as {0,obj,0}, {0,obj,1}, {1,tm,0} and {1,tm,1} in states OBJ0, OBJ1, TM0 and TM1 respectively; o_PALADDR SHALL hold its last value in IDLE and CAP.
REQ-018 SHALL capture i_PALDATA one clock after each address into staging registers: obj {R,G}, obj {B,I}, tm {R,G}, tm {B,I}.
REQ-019 SHALL set a complete flag when the TM1 data has been captured (end of CAP).
REQ-020 SHALL, at the next i_PCEN, transfer all staging values to the outputs simultaneously, giving a latency of exactly one pixel slot.
REQ-021 SHALL zero the obj outputs at that transfer if the object code was transparent.
REQ-022 SHALL set o_TMEN = NOT (tm code transparent) at that transfer.
REQ-023 SHALL set o_OUTEN = NOT blank at that transfer.
REQ-024 SHALL, if i_PCEN arrives while the complete flag is 0, still transfer the outputs, set o_OVERRUN, and restart the fetch per REQ-016.
REQ-025 SHALL not clear o_OVERRUN except by reset.
REQ-026 SHALL hold all outputs between i_PCEN pulses.
REQ-027 SHALL, when i_PCEN coincides with CAP, capture the TM1 data first and then perform the transfer in the same edge, so the current pixel is complete.

Reset
REQ-028 SHALL, while i_EMU_MRST_n=0 at a clock edge, set state=IDLE, o_PALADDR=0, all colour outputs=0, o_TMEN=0, o_OUTEN=0, o_OVERRUN=0, and the complete flag=1 (so the first transfer is not an overrun).
REQ-029 SHALL, on reset asserted mid-fetch, discard the fetch, and the first i_PCEN after release SHALL start cleanly.

Structure
REQ-030 SHALL place the state encoding, the 4'hF transparent code, and the address select/byte bit positions in the shared video package.
REQ-031 SHALL have no sub-module; the blender stage consumes the outputs directly, one instance per channel.

Verification
REQ-032 SHALL cover: i_PCEN every 8 clocks, obj=0x012, tm=0x034, RAM returns obj AB/CD and tm 12/34 -> after the next i_PCEN, OBJ R=A, G=B, B=C, I=D; TM R=1, G=2, B=3, I=4; o_TMEN=1, o_OUTEN=1.
REQ-033 SHALL cover: obj code 0x01F -> obj nibbles all 0; tm code 0x03F -> o_TMEN=0.
REQ-034 SHALL cover: i_BLANK=1 with the pixel -> o_OUTEN=0 one slot later; i_BLANK=0 on the next pixel -> o_OUTEN=1.
REQ-035 SHALL cover: i_PCEN 3 clocks after the previous one -> o_OVERRUN=1 and stays 1; the following pixels at 8-clock spacing are correct.
REQ-036 SHALL cover: reset asserted in state TM0 -> all outputs 0 next clock; after release, i_PCEN -> o_PALADDR sequence {0,obj,0}... restarts, and o_OVERRUN=0.
REQ-037 SHALL cover: i_PCEN exactly 5 clocks apart (in CAP) -> no overrun and correct data.
